// File: rtl/pong_input_conditioner_pkg.sv
// Shared constants for the pong input conditioner: video geometry, clock rate,
// the default tuning values for debounce and the CPU tracker, and a helper
// that sizes the debounce counter.
package pong_input_conditioner_pkg;

   localparam int unsigned H_VIDEO             = 640;
   localparam int unsigned V_VIDEO             = 480;
   localparam int unsigned CLK_HZ              = 25_175_000;
   localparam int unsigned DEF_SQ_WIDTH        = 16;
   localparam int unsigned DEF_PDL_HEIGHT      = 96;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 251_750;
   localparam int unsigned DEF_AI_DEADBAND     = 8;

   // Bit positions of the four channels in the packed button / press vectors
   typedef enum int unsigned {
      BTN_UP_P1 = 0,
      BTN_DN_P1 = 1,
      BTN_UP_P2 = 2,
      BTN_DN_P2 = 3
   } btn_idx_e;

   // Counter width for a debounce window; never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pong_input_conditioner_button_debounce.sv
// button_debounce: one active-low button channel. Two-flop synchroniser,
// stability counter, accepted level and a one-cycle press pulse that is
// aligned with the falling edge of the registered level output.
module button_debounce
   import pong_input_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk_0,
   input  logic rst,
   input  logic btn_n,
   output logic level_n,
   output logic press
);

   localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic          stable;
   logic [CW-1:0] cnt;

   // Synchronise, count consecutive disagreeing cycles, accept and register the level
   always_ff @(posedge clk_0) begin
      if (!rst) begin
         s1      <= 1'b1;
         s2      <= 1'b1;
         stable  <= 1'b1;
         cnt     <= '0;
         level_n <= 1'b1;
         press   <= 1'b0;
      end else begin
         s1 <= btn_n;
         s2 <= s1;
         if (s2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= s2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
         level_n <= stable;
         // level_n still holds the previous accepted level here, so this
         // fires exactly once per accepted 1->0 change and never on release
         press   <= level_n & ~stable;
      end
   end

endmodule

// File: rtl/pong_input_conditioner.sv
// pong_input_conditioner: debounces the four raw active-low player buttons
// and produces the clean up/down levels plus one-cycle press pulses.
// Optional feature macro: P2_AI_EN (CPU ball tracker drives player 2 levels).
module pong_input_conditioner
   import pong_input_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned SQ_WIDTH        = DEF_SQ_WIDTH,
   parameter int unsigned PDL_HEIGHT      = DEF_PDL_HEIGHT,
   parameter int unsigned AI_DEADBAND     = DEF_AI_DEADBAND
) (
   input  logic       clk_0,
   input  logic       rst,
   input  logic       btn_up_p1_n,
   input  logic       btn_dn_p1_n,
   input  logic       btn_up_p2_n,
   input  logic       btn_dn_p2_n,
   input  logic [9:0] sq_ypos,
   input  logic [9:0] pdl2_ypos,
   output logic       up_p1,
   output logic       down_p1,
   output logic       up_p2,
   output logic       down_p2,
   output logic [3:0] btn_press
);

   logic [3:0] raw_n;
   logic [3:0] lvl_n;

   assign raw_n = {btn_dn_p2_n, btn_up_p2_n, btn_dn_p1_n, btn_up_p1_n};

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_p1 (
      .clk_0(clk_0), .rst(rst), .btn_n(raw_n[BTN_UP_P1]),
      .level_n(lvl_n[BTN_UP_P1]), .press(btn_press[BTN_UP_P1]));

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn_p1 (
      .clk_0(clk_0), .rst(rst), .btn_n(raw_n[BTN_DN_P1]),
      .level_n(lvl_n[BTN_DN_P1]), .press(btn_press[BTN_DN_P1]));

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_p2 (
      .clk_0(clk_0), .rst(rst), .btn_n(raw_n[BTN_UP_P2]),
      .level_n(lvl_n[BTN_UP_P2]), .press(btn_press[BTN_UP_P2]));

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn_p2 (
      .clk_0(clk_0), .rst(rst), .btn_n(raw_n[BTN_DN_P2]),
      .level_n(lvl_n[BTN_DN_P2]), .press(btn_press[BTN_DN_P2]));

   assign up_p1   = lvl_n[BTN_UP_P1];
   assign down_p1 = lvl_n[BTN_DN_P1];

`ifdef P2_AI_EN
   logic [10:0] bc;
   logic [10:0] pc;
   logic        ai_up_n;
   logic        ai_dn_n;
   logic        unused_p2_lvl;

   // Ball and paddle centres; 11 bits so the offsets and deadband never wrap
   always_comb begin
      bc = {1'b0, sq_ypos}   + 11'(SQ_WIDTH / 2);
      pc = {1'b0, pdl2_ypos} + 11'(PDL_HEIGHT / 2);
   end

   // Registered tracker: steer the paddle centre toward the ball centre
   always_ff @(posedge clk_0) begin
      if (!rst) begin
         ai_up_n <= 1'b1;
         ai_dn_n <= 1'b1;
      end else if ((bc + 11'(AI_DEADBAND)) < pc) begin
         ai_up_n <= 1'b0;
         ai_dn_n <= 1'b1;
      end else if (bc > (pc + 11'(AI_DEADBAND))) begin
         ai_up_n <= 1'b1;
         ai_dn_n <= 1'b0;
      end else begin
         ai_up_n <= 1'b1;
         ai_dn_n <= 1'b1;
      end
   end

   assign up_p2         = ai_up_n;
   assign down_p2       = ai_dn_n;
   assign unused_p2_lvl = ^lvl_n[3:2];
`else
   logic unused_ai_in;

   assign up_p2        = lvl_n[BTN_UP_P2];
   assign down_p2      = lvl_n[BTN_DN_P2];
   assign unused_ai_in = ^{sq_ypos, pdl2_ypos};
`endif

endmodule

// File: tb/tb_pong_input_conditioner.sv
// Testbench for pong_input_conditioner with DEBOUNCE_CYCLES=4. Expected
// levels/pulses come from a window model of the raw button history and are
// queued per clock edge; a monitor pops and compares after each edge.
// Honours P2_AI_EN when the design is built with it.
module tb_pong_input_conditioner;

   localparam int unsigned DC  = 4;
   localparam int unsigned SQW = 16;
   localparam int unsigned PDH = 96;
   localparam int unsigned DB  = 8;
   localparam int unsigned HD  = DC + 3;

   logic       clk_0 = 1'b0;
   logic       rst   = 1'b0;
   logic [3:0] btn_n = '0;
   logic [9:0] sq_ypos   = '0;
   logic [9:0] pdl2_ypos = '0;
   logic       up_p1, down_p1, up_p2, down_p2;
   logic [3:0] btn_press;

   always #20 clk_0 = ~clk_0;

   pong_input_conditioner #(
      .DEBOUNCE_CYCLES(DC),
      .SQ_WIDTH(SQW),
      .PDL_HEIGHT(PDH),
      .AI_DEADBAND(DB)
   ) dut (
      .clk_0(clk_0),
      .rst(rst),
      .btn_up_p1_n(btn_n[0]),
      .btn_dn_p1_n(btn_n[1]),
      .btn_up_p2_n(btn_n[2]),
      .btn_dn_p2_n(btn_n[3]),
      .sq_ypos(sq_ypos),
      .pdl2_ypos(pdl2_ypos),
      .up_p1(up_p1),
      .down_p1(down_p1),
      .up_p2(up_p2),
      .down_p2(down_p2),
      .btn_press(btn_press)
   );

   typedef struct {
      int unsigned cyc;
      logic [3:0]  lvl;
      logic [3:0]  press;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;

   // hist[j] = raw buttons sampled j edges before the current one
   logic [3:0] hist [HD];
   logic [3:0] model_lvl = '1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus and queue the outputs expected at that edge
   task automatic step(input logic [3:0] b, input logic r);
      logic [3:0] prev;
      logic [3:0] nxt;
      logic [3:0] exp_lvl;
      logic [3:0] exp_press;
      int         bc, pc;
      @(negedge clk_0);
      btn_n = b;
      rst   = r;
      prev  = model_lvl;
      if (!r) begin
         for (int j = 0; j < HD; j++) hist[j] = '1;
         nxt = '1;
      end else begin
         for (int j = HD - 1; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = b;
         nxt = prev;
         for (int c = 0; c < 4; c++) begin
            logic all0, all1;
            all0 = 1'b1;
            all1 = 1'b1;
            for (int j = 3; j < HD; j++) begin
               if (hist[j][c]) all0 = 1'b0;
               else            all1 = 1'b0;
            end
            if (all0) nxt[c] = 1'b0;
            if (all1) nxt[c] = 1'b1;
         end
      end
      model_lvl = nxt;
      exp_press = r ? (prev & ~nxt) : 4'b0000;
      exp_lvl   = nxt;
`ifdef P2_AI_EN
      bc = int'(sq_ypos) + int'(SQW / 2);
      pc = int'(pdl2_ypos) + int'(PDH / 2);
      if (!r)                      exp_lvl[3:2] = 2'b11;
      else if (bc + int'(DB) < pc) exp_lvl[3:2] = 2'b10;
      else if (bc > pc + int'(DB)) exp_lvl[3:2] = 2'b01;
      else                         exp_lvl[3:2] = 2'b11;
`else
      bc = 0;
      pc = 0;
`endif
      sb.push_back('{cyc: cyc + 1, lvl: exp_lvl, press: exp_press});
      @(posedge clk_0);
      #2;
   endtask

   // Monitor: compare DUT outputs against the entry queued for this edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_0);
         cyc++;
         #1;
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("levels", {28'd0, down_p2, up_p2, down_p1, up_p1}, {28'd0, e.lvl});
            check("press", {28'd0, btn_press}, {28'd0, e.press});
         end
      end
   end

   initial begin
      int         fall;
      logic [3:0] b;
      logic       r;

      for (int j = 0; j < HD; j++) hist[j] = '1;
      pdl2_ypos = 10'd191;
      sq_ypos   = 10'd231;

      // 1: reset held with all buttons pressed, then release
      for (int i = 0; i < 5; i++) step(4'b0000, 1'b0);
      fall = -1;
      for (int i = 0; i < 12; i++) begin
         step(4'b0000, 1'b1);
         if (up_p1 === 1'b0 && fall < 0) fall = i;
      end
      check("p1_latency", fall, 6);
      for (int i = 0; i < 10; i++) step(4'b1111, 1'b1);

      // 2: short glitch on P1 up
      for (int i = 0; i < 3; i++)  step(4'b1110, 1'b1);
      for (int i = 0; i < 10; i++) step(4'b1111, 1'b1);

      // 3: P2 down held, then released
      for (int i = 0; i < 12; i++) step(4'b0111, 1'b1);
      for (int i = 0; i < 10; i++) step(4'b1111, 1'b1);

      // 4: all four pressed together, then released
      for (int i = 0; i < 10; i++) step(4'b0000, 1'b1);
      for (int i = 0; i < 10; i++) step(4'b1111, 1'b1);

      // 5: reset mid-debounce on P1 up, then a full fresh window
      for (int i = 0; i < 4; i++)  step(4'b1110, 1'b1);
      step(4'b1110, 1'b0);
      for (int i = 0; i < 10; i++) step(4'b1110, 1'b1);
      for (int i = 0; i < 10; i++) step(4'b1111, 1'b1);

      // 6: tracker positions (P2 levels follow the buttons in the default build)
      for (int k = 0; k < 6; k++) begin
         case (k)
            0: sq_ypos = 10'd100;
            1: sq_ypos = 10'd400;
            2: sq_ypos = 10'd231;
            3: sq_ypos = 10'd222;
            4: sq_ypos = 10'd240;
            default: sq_ypos = 10'd239;
         endcase
         for (int i = 0; i < 3; i++) step(4'b1111, 1'b1);
      end

      // Random runs and glitches with occasional resets
      b = 4'b1111;
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < 4; c++)
            if ($urandom_range(0, 4) == 0) b[c] = ~b[c];
         r = ($urandom_range(0, 59) != 0);
         sq_ypos   = 10'($urandom_range(0, 479));
         pdl2_ypos = 10'($urandom_range(0, 383));
         step(b, r);
      end
      for (int i = 0; i < 12; i++) step(4'b1111, 1'b1);

      check("sb_drain", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
